// File: rtl/mmio_dram_gen2_pkg.sv
// Shared definitions for the mmio_dram_gen2 memory/IO block.
// Holds the default geometry, the IO window base calculation and the
// positions of the STATUS and TIMER registers, counted down from the
// top of the address space.
package mmio_dram_gen2_pkg;

  localparam int unsigned DefAw   = 8;
  localparam int unsigned DefDw   = 8;
  localparam int unsigned DefNIn  = 2;
  localparam int unsigned DefNOut = 6;

  // STATUS and TIMER are the last two words of the address space.
  localparam int unsigned StatusFromTop = 2;
  localparam int unsigned TimerFromTop  = 1;

  // First IO address. Everything below it is RAM.
  function automatic int unsigned io_base(input int unsigned aw, input int unsigned n_in,
                                          input int unsigned n_out);
    return (32'd1 << aw) - (n_in + n_out + 2);
  endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// One input port: 2-flop synchroniser, change detector and sticky NEW flag.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   in_i          : asynchronous port value
//   clr_i         : request to clear NEW this edge (a change detected on the
//                   same edge wins)
//   sync_o        : synchronised value (lags in_i by two edges)
//   new_o         : NEW flag
module mmio_in_sync #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] in_i,
  input  logic          clr_i,
  output logic [DW-1:0] sync_o,
  output logic          new_o
);

  logic [DW-1:0] sync1_q, sync2_q, prev_q;
  logic          new_q, new_d;

  // Set has priority over clear.
  always_comb begin
    new_d = (sync2_q != prev_q) | (new_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      new_q   <= new_d;
    end
  end

  assign sync_o = sync2_q;
  assign new_o  = new_q;

endmodule

// File: rtl/mmio_dram_gen2.sv
// Word-addressed RAM with a small memory-mapped IO window at the top.
// Map: RAM [0, IO_BASE), inputs, outputs, STATUS, TIMER.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   ADDR, DATA : word address and write data
//   MW, MR     : write enable, consuming-read strobe
//   IN_DATA    : N_IN asynchronous input ports, DW bits each
//   OUT_DATA   : N_OUT output registers, DW bits each
//   OUT_STB    : one-cycle pulse per output after it is written
//   Q          : combinational read data
module mmio_dram_gen2
  import mmio_dram_gen2_pkg::*;
#(
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned N_OUT = DefNOut
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [AW-1:0]       ADDR,
  input  logic [DW-1:0]       DATA,
  input  logic                MW,
  input  logic                MR,
  input  logic [N_IN*DW-1:0]  IN_DATA,
  output logic [N_OUT*DW-1:0] OUT_DATA,
  output logic [N_OUT-1:0]    OUT_STB,
  output logic [DW-1:0]       Q
);

  localparam int unsigned IO_BASE = io_base(AW, N_IN, N_OUT);
  localparam logic [AW-1:0] IoBaseAddr = AW'(IO_BASE);
  localparam logic [AW-1:0] StatusAddr = AW'((32'd1 << AW) - StatusFromTop);
  localparam logic [AW-1:0] TimerAddr  = AW'((32'd1 << AW) - TimerFromTop);

  if ((N_IN + N_OUT + 2) > (32'd1 << (AW - 1))) begin : g_bad_map
    $error("IO window larger than half the address space");
  end
  if (N_IN < 1 || N_IN > DW || N_OUT < 1 || N_OUT > 32) begin : g_bad_ports
    $error("port count out of range");
  end

  logic [DW-1:0]       mem [IO_BASE];
  logic [DW-1:0]       sync_val [N_IN];
  logic [N_IN-1:0]     new_flag;
  logic [N_IN-1:0]     clr;
  logic [N_OUT-1:0]    out_we;
  logic [N_OUT*DW-1:0] out_q;
  logic [N_OUT-1:0]    stb_q;
  logic [DW-1:0]       timer_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    // Clear by consuming read of the port, or write-1-to-clear via STATUS.
    assign clr[i] = (MR && !MW && ADDR == AW'(IO_BASE + i)) ||
                    (MW && ADDR == StatusAddr && DATA[i]);

    mmio_in_sync #(
      .DW(DW)
    ) u_in_sync (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .in_i  (IN_DATA[i*DW +: DW]),
      .clr_i (clr[i]),
      .sync_o(sync_val[i]),
      .new_o (new_flag[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign out_we[j] = MW && ADDR == AW'(IO_BASE + N_IN + j);
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (MW && ADDR < IoBaseAddr) begin
      mem[ADDR] <= DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      stb_q   <= '0;
      timer_q <= '0;
    end else begin
      stb_q <= out_we;
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (out_we[j]) begin
          out_q[j*DW +: DW] <= DATA;
        end
      end
      // A load replaces the increment for that cycle.
      if (MW && ADDR == TimerAddr) begin
        timer_q <= DATA;
      end else begin
        timer_q <= timer_q + DW'(1);
      end
    end
  end

  always_comb begin
    Q = '0;
    if (ADDR < IoBaseAddr) begin
      Q = mem[ADDR];
    end else if (ADDR == StatusAddr) begin
      Q = DW'(new_flag);
    end else if (ADDR == TimerAddr) begin
      Q = timer_q;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (ADDR == AW'(IO_BASE + i)) begin
          Q = sync_val[i];
        end
      end
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (ADDR == AW'(IO_BASE + N_IN + j)) begin
          Q = out_q[j*DW +: DW];
        end
      end
    end
  end

  assign OUT_DATA = out_q;
  assign OUT_STB  = stb_q;

endmodule

// File: tb/tb_mmio_dram_gen2.sv
module tb_mmio_dram_gen2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  ADDR;
  logic [7:0]  DATA;
  logic        MW;
  logic        MR;
  logic [15:0] IN_DATA;
  logic [47:0] OUT_DATA;
  logic [5:0]  OUT_STB;
  logic [7:0]  Q;

  int total = 0;
  int bad   = 0;

  mmio_dram_gen2 dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .MW      (MW),
    .MR      (MR),
    .IN_DATA (IN_DATA),
    .OUT_DATA(OUT_DATA),
    .OUT_STB (OUT_STB),
    .Q       (Q)
  );

  always #5 CLK = ~CLK;

  // Reference model: map 0..245 RAM, 246..247 inputs, 248..253 outputs,
  // 254 STATUS, 255 TIMER.
  logic [7:0]  ram_m [246];
  bit          written [246];
  logic [7:0]  out_m [6];
  logic [5:0]  stb_m;
  logic [1:0]  new_m;
  logic [7:0]  timer_m;
  // IN_DATA samples, newest first; element 1 is what is visible to reads.
  logic [15:0] hist [$];

  task automatic model_reset();
    for (int j = 0; j < 6; j++) out_m[j] = 8'h00;
    stb_m   = 6'b0;
    new_m   = 2'b0;
    timer_m = 8'h00;
    hist    = {16'h0, 16'h0, 16'h0};
  endtask

  function automatic logic [47:0] out_flat();
    logic [47:0] r;
    for (int j = 0; j < 6; j++) r[j*8 +: 8] = out_m[j];
    return r;
  endfunction

  function automatic logic [7:0] exp_q(input logic [7:0] a);
    logic [15:0] v;
    v = hist[1];
    if (a < 8'd246) return ram_m[a];
    if (a == 8'd246) return v[7:0];
    if (a == 8'd247) return v[15:8];
    if (a < 8'd254) return out_m[a - 8'd248];
    if (a == 8'd254) return {6'b0, new_m};
    return timer_m;
  endfunction

  task automatic model_edge(input logic [7:0] a, input logic [7:0] d, input logic w,
                            input logic r, input logic [15:0] in_v);
    logic [15:0] vis, prv;
    logic set_i, clr_i;
    vis = hist[1];
    prv = hist[2];
    for (int i = 0; i < 2; i++) begin
      set_i = vis[i*8 +: 8] != prv[i*8 +: 8];
      clr_i = (r && !w && a == 8'(246 + i)) || (w && a == 8'd254 && d[i]);
      new_m[i] = set_i || (new_m[i] && !clr_i);
    end
    hist.push_front(in_v);
    void'(hist.pop_back());
    if (w && a < 8'd246) begin
      ram_m[a]   = d;
      written[a] = 1'b1;
    end
    stb_m = 6'b0;
    if (w && a >= 8'd248 && a < 8'd254) begin
      out_m[a - 8'd248] = d;
      stb_m[a - 8'd248] = 1'b1;
    end
    timer_m = (w && a == 8'd255) ? d : timer_m + 8'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, check current state, take one rising edge.
  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w,
                     input logic r, input logic [15:0] in_v);
    ADDR = a; DATA = d; MW = w; MR = r; IN_DATA = in_v;
    #1;
    if (!(a < 8'd246 && !written[a])) chk("q", {56'b0, Q}, {56'b0, exp_q(a)});
    chk("out_data", {16'b0, OUT_DATA}, {16'b0, out_flat()});
    chk("out_stb", {58'b0, OUT_STB}, {58'b0, stb_m});
    @(posedge CLK);
    model_edge(a, d, w, r, in_v);
    @(negedge CLK);
  endtask

  task automatic look(input string tag, input logic [7:0] a, input logic [7:0] exp);
    ADDR = a; MW = 1'b0; MR = 1'b0;
    #1;
    chk(tag, {56'b0, Q}, {56'b0, exp});
  endtask

  logic [15:0] in_r;
  logic [7:0]  ra;

  initial begin
    RST_N = 1'b0; ADDR = 8'd255; DATA = 8'h00; MW = 1'b0; MR = 1'b0; IN_DATA = 16'h0;
    model_reset();
    #1;
    chk("rst_out_data", {16'b0, OUT_DATA}, 64'h0);
    chk("rst_out_stb", {58'b0, OUT_STB}, 64'h0);
    chk("rst_timer", {56'b0, Q}, 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // No NEW activity straight out of reset with quiet inputs.
    cyc(8'd254, 8'h00, 1'b0, 1'b0, 16'h0);
    cyc(8'd254, 8'h00, 1'b0, 1'b0, 16'h0);
    look("status_quiet", 8'd254, 8'h00);

    // RAM write/read; writes to an input are ignored.
    cyc(8'd10, 8'hA5, 1'b1, 1'b0, 16'h0);
    look("ram10", 8'd10, 8'hA5);
    cyc(8'd246, 8'hFF, 1'b1, 1'b0, 16'h0);
    look("in0_ignored", 8'd246, 8'h00);
    look("status_after_in_wr", 8'd254, 8'h00);

    // Input 1 lags by two edges, then flags NEW; consuming read clears it.
    cyc(8'd247, 8'h00, 1'b0, 1'b0, 16'h3C00);
    look("in1_lag1", 8'd247, 8'h00);
    cyc(8'd247, 8'h00, 1'b0, 1'b0, 16'h3C00);
    look("in1_lag2", 8'd247, 8'h3C);
    cyc(8'd0, 8'h00, 1'b0, 1'b0, 16'h3C00);
    look("status_new1", 8'd254, 8'h02);
    cyc(8'd247, 8'h00, 1'b0, 1'b1, 16'h3C00);
    look("status_clr1", 8'd254, 8'h00);

    // Change lands on the same edge as the clearing read: set wins.
    cyc(8'd0, 8'h00, 1'b0, 1'b0, 16'h5500);
    cyc(8'd0, 8'h00, 1'b0, 1'b0, 16'h5500);
    cyc(8'd247, 8'h00, 1'b0, 1'b1, 16'h5500);
    look("set_wins", 8'd254, 8'h02);
    // Write-1-to-clear through STATUS.
    cyc(8'd254, 8'h02, 1'b1, 1'b0, 16'h5500);
    look("status_w1c", 8'd254, 8'h00);

    // Output 2 write and strobe.
    cyc(8'd250, 8'h7E, 1'b1, 1'b0, 16'h5500);
    chk("stb_out2", {58'b0, OUT_STB}, 64'h4);
    chk("out2_data", {56'b0, OUT_DATA[23:16]}, 64'h7E);
    look("rd250", 8'd250, 8'h7E);
    cyc(8'd0, 8'h00, 1'b0, 1'b0, 16'h5500);
    chk("stb_one_cycle", {58'b0, OUT_STB}, 64'h0);

    // Timer load and wrap.
    cyc(8'd255, 8'hFE, 1'b1, 1'b0, 16'h5500);
    look("tmr_fe", 8'd255, 8'hFE);
    cyc(8'd255, 8'h00, 1'b0, 1'b0, 16'h5500);
    look("tmr_ff", 8'd255, 8'hFF);
    cyc(8'd255, 8'h00, 1'b0, 1'b0, 16'h5500);
    look("tmr_00", 8'd255, 8'h00);

    // Randomised traffic, biased towards the IO window.
    in_r = 16'h5500;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 8'($urandom_range(0, 245));
      else ra = 8'($urandom_range(240, 255));
      if ($urandom_range(0, 3) == 0) in_r = 16'($urandom);
      cyc(ra, 8'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), in_r);
    end

    // Reset between edges while a strobe is pending.
    cyc(8'd10, 8'hA5, 1'b1, 1'b0, in_r);
    cyc(8'd251, 8'h33, 1'b1, 1'b0, in_r);
    chk("stb_before_rst", {58'b0, OUT_STB}, 64'h8);
    ADDR = 8'd255; MW = 1'b0; MR = 1'b0; IN_DATA = 16'h0;
    #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_out_data", {16'b0, OUT_DATA}, 64'h0);
    chk("rst_mid_out_stb", {58'b0, OUT_STB}, 64'h0);
    chk("rst_mid_timer", {56'b0, Q}, 64'h0);
    RST_N = 1'b1;
    look("ram10_kept", 8'd10, 8'hA5);
    @(negedge CLK);
    cyc(8'd254, 8'h00, 1'b0, 1'b0, 16'h0);
    cyc(8'd254, 8'h00, 1'b0, 1'b0, 16'h0);
    cyc(8'd254, 8'h00, 1'b0, 1'b0, 16'h0);
    look("status_after_rst", 8'd254, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
